// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_sequencer slice: opcode and FSM state
// enumerations, instruction field positions and opcode classification helpers.
`timescale 1ns/1ps
package cpu_pkg;

    localparam int INSTR_W = 16;

    // Instruction field positions.
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    // Encodings 9..15 are unused and treated as illegal.
    typedef enum logic [3:0] {
        OP_NOP = 4'd0,
        OP_ADD = 4'd1,
        OP_SUB = 4'd2,
        OP_AND = 4'd3,
        OP_OR  = 4'd4,
        OP_XOR = 4'd5,
        OP_LDI = 4'd6,
        OP_SHL = 4'd7,
        OP_SHR = 4'd8
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_EXECUTE   = 2'd2,
        ST_WRITEBACK = 2'd3
    } state_e;

    // Opcodes that produce a register-file write.
    function automatic logic is_write_op(input opcode_e opc);
        return (opc >= OP_ADD) && (opc <= OP_SHR);
    endfunction

    function automatic logic is_legal_op(input opcode_e opc);
        return opc <= OP_SHR;
    endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// Instruction handshake and register-file bus of the cpu_sequencer.
// The master modport is the sequencer side, the slave modport the
// instruction source / register file side. With CPU_SEQUENCER_FLAGS_EN
// defined the bus also carries the flag_z/flag_c status outputs.
`timescale 1ns/1ps
interface cpu_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [15:0]       instr;
    logic              instr_valid;
    logic              instr_ready;
    logic [ADDR_W-1:0] rf_raddr1;
    logic [ADDR_W-1:0] rf_raddr2;
    logic [DATA_W-1:0] rf_rdata1;
    logic [DATA_W-1:0] rf_rdata2;
    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic              done;
    logic              illegal;
`ifdef CPU_SEQUENCER_FLAGS_EN
    logic              flag_z;
    logic              flag_c;

    modport master (
        input  instr, instr_valid, rf_rdata1, rf_rdata2,
        output instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               done, illegal, flag_z, flag_c
    );

    modport slave (
        output instr, instr_valid, rf_rdata1, rf_rdata2,
        input  instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               done, illegal, flag_z, flag_c
    );
`else
    modport master (
        input  instr, instr_valid, rf_rdata1, rf_rdata2,
        output instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               done, illegal
    );

    modport slave (
        output instr, instr_valid, rf_rdata1, rf_rdata2,
        input  instr_ready, rf_raddr1, rf_raddr2, rf_we, rf_waddr, rf_wdata,
               done, illegal
    );
`endif
endinterface

// File: rtl/cpu_alu.sv
// Combinational ALU: maps opcode plus operands/immediate to a result and a
// carry (ADD carry-out, SUB borrow, 0 for everything else). Results wrap
// modulo 2^DATA_W.
`timescale 1ns/1ps
module cpu_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  opcode_e           opcode_i,
    input  logic [7:0]        imm8_i,
    output logic [DATA_W-1:0] result_o,
    output logic              carry_o
);

    // One extra bit captures carry-out / borrow.
    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;

    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    // Opcode decode to result; NOP and illegal opcodes yield zero.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        result_o = '0;
        carry_o  = 1'b0;
        case (opcode_i)
            OP_ADD: begin
                result_o = sum[DATA_W-1:0];
                carry_o  = sum[DATA_W];
            end
            OP_SUB: begin
                result_o = diff[DATA_W-1:0];
                carry_o  = diff[DATA_W];
            end
            OP_AND:  result_o = a_i & b_i;
            OP_OR:   result_o = a_i | b_i;
            OP_XOR:  result_o = a_i ^ b_i;
            OP_LDI:  result_o = DATA_W'(imm8_i);
            OP_SHL:  result_o = a_i << b_i[3:0];
            OP_SHR:  result_o = a_i >> b_i[3:0];
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle instruction sequencer: IDLE -> DECODE -> EXECUTE -> WRITEBACK.
// Accepts one instruction in IDLE, reads its operands from an external
// register file in DECODE, computes in EXECUTE and writes back in WRITEBACK.
// Optional feature: define CPU_SEQUENCER_FLAGS_EN to add zero/carry flags.
`timescale 1ns/1ps
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input logic             clk,
    input logic             reset,
    cpu_sequencer_if.master bus
);

    state_e               state_q, state_d;
    logic [INSTR_W-1:0]   instr_q;
    logic [DATA_W-1:0]    op_a_q;
    logic [DATA_W-1:0]    op_b_q;
    logic [DATA_W-1:0]    result_q;

    logic                 accept;
    logic                 instr_ready;
    logic [ADDR_W-1:0]    rf_raddr1;
    logic [ADDR_W-1:0]    rf_raddr2;
    logic                 rf_we;
    logic [ADDR_W-1:0]    rf_waddr;
    logic [DATA_W-1:0]    rf_wdata;
    logic                 done;
    logic                 illegal;

    logic [DATA_W-1:0]    alu_result;
    logic                 alu_carry;

    // Latched instruction fields.
    opcode_e              opc;
    logic [3:0]           rd;
    logic [3:0]           rs1;
    logic [3:0]           rs2;
    logic [7:0]           imm8;

    assign opc  = opcode_e'(instr_q[OPC_MSB:OPC_LSB]);
    assign rd   = instr_q[RD_MSB:RD_LSB];
    assign rs1  = instr_q[RS1_MSB:RS1_LSB];
    assign rs2  = instr_q[RS2_MSB:RS2_LSB];
    assign imm8 = instr_q[IMM_MSB:IMM_LSB];

    cpu_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i      (op_a_q),
        .b_i      (op_b_q),
        .opcode_i (opc),
        .imm8_i   (imm8),
        .result_o (alu_result),
        .carry_o  (alu_carry)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and per-state bus outputs.
    always_comb begin
        state_d     = state_q;
        accept      = 1'b0;
        instr_ready = 1'b0;
        rf_raddr1   = '0;
        rf_raddr2   = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        done        = 1'b0;
        illegal     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (bus.instr_valid) begin
                    accept  = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                rf_raddr1 = ADDR_W'(rs1);
                rf_raddr2 = ADDR_W'(rs2);
                state_d   = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                state_d = ST_WRITEBACK;
            end
            ST_WRITEBACK: begin
                done    = 1'b1;
                illegal = !is_legal_op(opc);
                if (is_write_op(opc)) begin
                    rf_we    = 1'b1;
                    rf_waddr = ADDR_W'(rd);
                    rf_wdata = result_q;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // NOTE: reset is synchronous, so the outputs are forced combinationally as well;
        // otherwise a reset landing in WRITEBACK would still write the register file that cycle.
        if (reset) begin
            state_d     = ST_IDLE;
            accept      = 1'b0;
            instr_ready = 1'b1;
            rf_raddr1   = '0;
            rf_raddr2   = '0;
            rf_we       = 1'b0;
            rf_waddr    = '0;
            rf_wdata    = '0;
            done        = 1'b0;
            illegal     = 1'b0;
        end
    end

    // Instruction latch, operand capture and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q  <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                instr_q <= bus.instr;
            end
            if (state_q == ST_DECODE) begin
                op_a_q <= bus.rf_rdata1;
                op_b_q <= bus.rf_rdata2;
            end
            if (state_q == ST_EXECUTE) begin
                result_q <= alu_result;
            end
        end
    end

`ifdef CPU_SEQUENCER_FLAGS_EN
    logic carry_q;
    logic flag_z_q;
    logic flag_c_q;

    // Carry is captured alongside the result; flags load when a writing
    // instruction leaves WRITEBACK and hold otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            carry_q  <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            if (state_q == ST_EXECUTE) begin
                carry_q <= alu_carry;
            end
            if (state_q == ST_WRITEBACK && is_write_op(opc)) begin
                flag_z_q <= (result_q == '0);
                flag_c_q <= carry_q;
            end
        end
    end

    assign bus.flag_z = flag_z_q;
    assign bus.flag_c = flag_c_q;
`else
    // Carry has no consumer without the flag feature.
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

    assign bus.instr_ready = instr_ready;
    assign bus.rf_raddr1   = rf_raddr1;
    assign bus.rf_raddr2   = rf_raddr2;
    assign bus.rf_we       = rf_we;
    assign bus.rf_waddr    = rf_waddr;
    assign bus.rf_wdata    = rf_wdata;
    assign bus.done        = done;
    assign bus.illegal     = illegal;

endmodule
